// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional build macro MULDIV_FAST_ZERO_EN lets zero operands skip the CALC phase.
module muldiv_unit #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         flush,
  input  logic [2:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX
  } state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_op;
  logic [N-1:0]     r_a;
  logic [N-1:0]     r_b;
  logic [N-1:0]     r_d;
  logic [2*N-1:0]   r_acc;
  logic [4:0]       r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [N-1:0]     r_out;
  logic             r_done;

  logic             w_a_signed;
  logic             w_b_signed;
  logic             w_sign_a;
  logic             w_sign_b;
  logic [N-1:0]     w_mag_a;
  logic [N-1:0]     w_mag_b;
  logic             w_fast_zero;
  logic [N:0]       w_mul_sum;
  logic [N:0]       w_div_diff;
  logic [2*N-1:0]   w_acc_next;
  logic [2*N-1:0]   w_prod;
  logic [N-1:0]     w_quot;
  logic [N-1:0]     w_rem;
  logic             w_div_zero;
  logic             w_ovf;
  logic [N-1:0]     w_result;

  // Operand signedness follows funct3: MULH/DIV/REM sign both, MULHSU signs only A.
  assign w_a_signed = (r_op == OP_MULH) || (r_op == OP_MULHSU) ||
                      (r_op == OP_DIV)  || (r_op == OP_REM);
  assign w_b_signed = (r_op == OP_MULH) || (r_op == OP_DIV) || (r_op == OP_REM);
  assign w_sign_a   = w_a_signed & r_a[N-1];
  assign w_sign_b   = w_b_signed & r_b[N-1];
  assign w_mag_a    = w_sign_a ? -r_a : r_a;
  assign w_mag_b    = w_sign_b ? -r_b : r_b;

`ifdef MULDIV_FAST_ZERO_EN
  assign w_fast_zero = r_op[2] ? (r_b == '0) : ((r_a == '0) || (r_b == '0));
`else
  assign w_fast_zero = 1'b0;
`endif

  // Multiply keeps the multiplier in the low half; divide keeps remainder:quotient.
  assign w_mul_sum  = {1'b0, r_acc[2*N-1:N]} + (r_acc[0] ? {1'b0, r_d} : '0);
  assign w_div_diff = r_acc[2*N-1:N-1] - {1'b0, r_d};
  assign w_acc_next = !r_op[2]       ? {w_mul_sum, r_acc[N-1:1]} :
                      !w_div_diff[N] ? {w_div_diff[N-1:0], r_acc[N-2:0], 1'b1} :
                                       {r_acc[2*N-2:0], 1'b0};

  assign w_prod     = r_neg_q ? -r_acc : r_acc;
  assign w_quot     = r_neg_q ? -r_acc[N-1:0] : r_acc[N-1:0];
  assign w_rem      = r_neg_r ? -r_acc[2*N-1:N] : r_acc[2*N-1:N];
  assign w_div_zero = (r_b == '0);
  assign w_ovf      = (r_a == {1'b1, {(N-1){1'b0}}}) && (r_b == '1);

  always_comb begin
    w_result = '0;
    case (r_op)
      OP_MUL:                      w_result = w_prod[N-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_result = w_prod[2*N-1:N];
      OP_DIV:  w_result = w_div_zero ? '1  : w_ovf ? {1'b1, {(N-1){1'b0}}} : w_quot;
      OP_DIVU: w_result = w_div_zero ? '1  : w_quot;
      OP_REM:  w_result = w_div_zero ? r_a : w_ovf ? '0 : w_rem;
      OP_REMU: w_result = w_div_zero ? r_a : w_rem;
      default: w_result = '0;
    endcase
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_PREP;
      S_PREP: w_next = w_fast_zero ? S_FIX : S_CALC;
      S_CALC: if (r_cnt == 5'd31) w_next = S_FIX;
      S_FIX:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_out   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!flush) begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_op <= op;
              r_a  <= inA;
              r_b  <= inB;
            end
          end
          S_PREP: begin
            r_neg_q <= w_sign_a ^ w_sign_b;
            r_neg_r <= w_sign_a;
            r_cnt   <= '0;
            if (r_op[2]) begin
              r_d   <= w_mag_b;
              r_acc <= {{N{1'b0}}, w_mag_a};
            end else begin
              r_d   <= w_mag_a;
              r_acc <= w_fast_zero ? '0 : {{N{1'b0}}, w_mag_b};
            end
          end
          S_CALC: begin
            r_cnt <= r_cnt + 5'd1;
            r_acc <= w_acc_next;
          end
          S_FIX: begin
            r_out  <= w_result;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign out  = r_out;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table plus handshake,
// flush and reset sequences. Honours MULDIV_FAST_ZERO_EN for latency expectations.
module tb_muldiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op    = '0;
  logic [31:0] inA   = '0;
  logic [31:0] inB   = '0;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.N(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .flush (flush),
    .op    (op),
    .inA   (inA),
    .inB   (inB),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [2:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] e,
                              input string n);
    vec_t v;
    v.op = o; v.a = a; v.b = b; v.exp = e; v.name = n;
    return v;
  endfunction

  // Edges counted after the start edge until done is seen; 34 means done is
  // valid in the cycle following the 34th edge, i.e. sampled at the 35th.
  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MULDIV_FAST_ZERO_EN
    if (o[2] ? (b == 32'd0) : ((a == 32'd0) || (b == 32'd0))) return 2;
`endif
    return 34;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Caller is at a negedge; start is sampled on the following posedge.
  // Operands are scrambled afterwards to prove the unit latched them.
  task automatic launch_now(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; inA = a; inB = b;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0; op = ~o; inA = ~a; inB = ~b;
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    launch_now(o, a, b);
  endtask

  task automatic wait_done(output int lat, output logic seen);
    lat  = 1;
    seen = 1'b0;
    @(posedge clock);
    @(negedge clock);
    while (!done && lat < 100) begin
      @(posedge clock);
      @(negedge clock);
      lat++;
    end
    seen = done;
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (done) cnt++;
    end
  endtask

  initial begin
    int   lat;
    logic seen;
    int   cnt;

    vecs.push_back(mk(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_m1_m1"));
    vecs.push_back(mk(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_m1_m1"));
    vecs.push_back(mk(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max_max"));
    vecs.push_back(mk(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, "mulhsu_m1_2"));
    vecs.push_back(mk(3'b000, 32'd7,         32'd6,         32'd42,        "mul_7_6"));
    vecs.push_back(mk(3'b011, 32'h8000_0000, 32'd4,         32'd2,         "mulhu_2p31_4"));
    vecs.push_back(mk(3'b000, 32'd0,         32'h0001_2345, 32'd0,         "mul_zero"));
    vecs.push_back(mk(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div_m7_2"));
    vecs.push_back(mk(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem_m7_2"));
    vecs.push_back(mk(3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2"));
    vecs.push_back(mk(3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         "rem_7_m2"));
    vecs.push_back(mk(3'b101, 32'd100,       32'd7,         32'd14,        "divu_100_7"));
    vecs.push_back(mk(3'b111, 32'd100,       32'd7,         32'd2,         "remu_100_7"));
    vecs.push_back(mk(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"));
    vecs.push_back(mk(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem_ovf"));
    vecs.push_back(mk(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, "divu_5_0"));
    vecs.push_back(mk(3'b111, 32'd5,         32'd0,         32'd5,         "remu_5_0"));
    vecs.push_back(mk(3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, "div_m7_0"));

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_out",  out,           32'd0);
    @(negedge clock);
    reset = 1'b1;

    // Vector table
    foreach (vecs[i]) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      check({vecs[i].name, "_busy"}, {31'd0, busy}, 32'd1);
      wait_done(lat, seen);
      check({vecs[i].name, "_done_seen"}, {31'd0, seen}, 32'd1);
      check({vecs[i].name, "_result"}, out, vecs[i].exp);
      check({vecs[i].name, "_latency"}, lat, exp_latency(vecs[i].op, vecs[i].a, vecs[i].b));
      @(posedge clock);
      @(negedge clock);
      check({vecs[i].name, "_done_single"}, {31'd0, done}, 32'd0);
      check({vecs[i].name, "_idle"}, {31'd0, busy}, 32'd0);
    end

    // start pulsed while busy is ignored: one done, first result kept
    launch(3'b000, 32'd7, 32'd6);
    repeat (4) @(negedge clock);
    start = 1'b1; op = 3'b101; inA = 32'd100; inB = 32'd7;
    @(negedge clock);
    start = 1'b0;
    count_dones(80, cnt);
    check("busy_start_done_count", cnt, 32'd1);
    check("busy_start_result", out, 32'd42);

    // Flush at cycle 20: no done, out keeps prior value
    launch(3'b101, 32'd100, 32'd7);
    repeat (18) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    count_dones(50, cnt);
    check("flush_done_count", cnt, 32'd0);
    check("flush_out_kept", out, 32'd42);

    // flush together with start in IDLE stays idle
    @(negedge clock);
    start = 1'b1; flush = 1'b1; op = 3'b000; inA = 32'd3; inB = 32'd3;
    @(negedge clock);
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", {31'd0, busy}, 32'd0);
    count_dones(40, cnt);
    check("flush_start_done_count", cnt, 32'd0);

    // Back-to-back: second start sampled in the done cycle
    launch(3'b011, 32'h8000_0000, 32'd4);
    wait_done(lat, seen);
    check("b2b_first_seen", {31'd0, seen}, 32'd1);
    check("b2b_first_result", out, 32'd2);
    launch_now(3'b101, 32'd100, 32'd7);
    check("b2b_done_low", {31'd0, done}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(lat, seen);
    check("b2b_second_seen", {31'd0, seen}, 32'd1);
    check("b2b_second_latency", lat, 32'd34);
    check("b2b_second_result", out, 32'd14);

    // Asynchronous reset mid-CALC
    launch(3'b000, 32'd7, 32'd6);
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_out",  out,           32'd0);
    @(negedge clock);
    reset = 1'b1;
    count_dones(50, cnt);
    check("midreset_done_count", cnt, 32'd0);
    check("midreset_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit that sits beside the single-cycle ALU in the EX stage. It accepts one operation per start pulse and computes the result with a radix-2 shift-add or restoring-divide datapath. It asserts `busy` so hazard logic stalls the pipeline, then returns a 32-bit result with a one-cycle `done` pulse. It serves the eight M-extension instructions, selected by funct3.

## Interface
- `N`, 32: operand/result width; only 32 is supported.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  launch operation; sampled only in IDLE.
- `flush`  in  1  synchronous abort (pipeline flush); has priority over `start`.
- `op`  in  3  funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `inA`  in  N  rs1 operand; dividend or multiplicand.
- `inB`  in  N  rs2 operand; divisor or multiplier.
- `busy`  out  1  high while an operation is in flight (PREP, CALC, FIX).
- `done`  out  1  one-cycle pulse; `out` is valid in this cycle.
- `out`  out  N  registered result; holds its value until the next `done`.

## Operation
- States and transitions:
  - IDLE → PREP on `start`.
  - PREP → CALC.
  - CALC → FIX after 32 iterations.
  - FIX → IDLE; `done` is asserted on entry to IDLE.
- IDLE → PREP latches `op`, `inA` and `inB`. Operands may change afterwards without effect.
- PREP: records result sign, converts signed operands to magnitude, clears the 64-bit accumulator and the 5-bit counter.
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - DIV/REM: both operands signed.
  - MULHU, DIVU, REMU: unsigned.
- CALC: one iteration per cycle; the counter increments each cycle and wraps 31 → 0 to leave CALC.
  - Multiply: if the multiplier LSB is set, add the multiplicand into the upper half; then shift the accumulator right.
  - Divide: shift the remainder:quotient pair left; trial-subtract the divisor; keep the result if non-negative and set the quotient bit.
- FIX: negate the product, quotient or remainder as required, then select the output.
  - MUL returns the low 32 bits; MULH/MULHSU/MULHU return the high 32 bits.
  - REM takes the sign of the dividend.
- Special cases, resolved in FIX with no extra cycles:
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- `start` while `busy` is ignored; no queueing.
- `flush` in any state returns to IDLE on the next edge.
  - No `done` is produced and `out` keeps its prior value.
  - `flush` and `start` in the same IDLE cycle: stay in IDLE.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `out`=0, counter 0.
- Reset is asynchronous and acts mid-operation; no `done` follows it.
- Latency: `start` sampled at edge E0.
  - `busy` is high from E0 through E34.
  - `done`=1 and `out` are valid for the single cycle after E34, which is 35 edges after E0.
- Throughput: a new `start` can be sampled in the same cycle that `done` is high (back-to-back, 35-cycle period).
- `done` is never high for two consecutive cycles.

## Configuration
- `MULDIV_FAST_ZERO_EN`
- Defined: if, in PREP, the multiplier or multiplicand is 0 (MUL*), or the divisor is 0 (DIV*/REM*), PREP jumps straight to FIX.
  - Result values are identical to the full-length computation.
  - `done` comes 3 edges after the `start` edge instead of 35.
- Undefined: every operation takes the full 35 cycles regardless of operand values; the zero-detect logic is not synthesized.

## Test plan
- Reset mid-CALC: start MUL 7×6, deassert `reset` at cycle 10 → `busy`=0, `out`=0 immediately; no `done` afterwards.
- MUL/MULH: 0xFFFFFFFF × 0xFFFFFFFF.
  - MUL → 0x00000001; MULH → 0x00000000; MULHU → 0xFFFFFFFE.
  - `done` exactly 35 cycles after `start`.
- MULHSU: 0xFFFFFFFF (−1) × 0x00000002 → 0xFFFFFFFF.
- Division signs: DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Corner cases:
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - With `MULDIV_FAST_ZERO_EN`, the divide-by-zero `done` arrives 3 cycles after `start`.
- Handshake:
  - `start` pulsed while busy → ignored; one `done` only.
  - `flush` at cycle 20 → IDLE, no `done`, `out` keeps the prior value.
  - `start` asserted in the `done` cycle → the second result arrives 35 cycles later.
